// File: rtl/write_pointer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : write_pointer_ctrl
// Purpose  : Write-domain pointer controller for an asynchronous FIFO of
//            depth 2**PTRWIDTH. Produces binary/Gray write pointers, RAM
//            write address/enable, registered full, fill level, almost-full
//            and a sticky overflow flag.
// Revision : 1.0  initial release
// ============================================================================
module write_pointer_ctrl #(
  parameter int PTRWIDTH = 3
) (
  input  logic                wclk,
  input  logic                wr_reset,
  input  logic                w_en,
  input  logic [PTRWIDTH:0]   g_rdptr_sync,
  input  logic [PTRWIDTH:0]   af_thresh,
  input  logic                ovf_clr,
  output logic [PTRWIDTH:0]   b_wrptr,
  output logic [PTRWIDTH:0]   g_wrptr,
  output logic [PTRWIDTH-1:0] wr_addr,
  output logic                wr_accept,
  output logic                full,
  output logic                almost_full,
  output logic [PTRWIDTH:0]   wr_level,
  output logic                overflow
);

  logic [PTRWIDTH:0] b_next;
  logic [PTRWIDTH:0] g_next;
  logic [PTRWIDTH:0] rd_bin;
  logic [PTRWIDTH:0] level_next;
  logic [PTRWIDTH:0] full_pattern;
  logic              full_next;
  logic              af_next;

  // A write only reaches the RAM when the FIFO is not already full.
  assign wr_accept = w_en & ~full;
  assign wr_addr   = b_wrptr[PTRWIDTH-1:0];

  assign b_next = b_wrptr + {{PTRWIDTH{1'b0}}, wr_accept};
  assign g_next = b_next ^ (b_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i <= PTRWIDTH; i++) begin : g_g2b
    assign rd_bin[i] = ^g_rdptr_sync[PTRWIDTH:i];
  end

  // Full when the next write pointer has lapped the read pointer exactly once:
  // in Gray code that is the read pointer with its two MSBs inverted.
  assign full_pattern = {~g_rdptr_sync[PTRWIDTH:PTRWIDTH-1], g_rdptr_sync[PTRWIDTH-2:0]};
  assign full_next    = (g_next == full_pattern);

  // Modulo subtraction absorbs pointer wrap-around.
  assign level_next = b_next - rd_bin;
  assign af_next    = (level_next >= af_thresh);

  // Pointer, status and level registers; reset overrides every other event.
  always_ff @(posedge wclk) begin
    if (wr_reset) begin
      b_wrptr     <= '0;
      g_wrptr     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      b_wrptr     <= b_next;
      g_wrptr     <= g_next;
      full        <= full_next;
      almost_full <= af_next;
      wr_level    <= level_next;
    end
  end

  // Sticky overflow: a request while full sets it, and setting beats clearing.
  always_ff @(posedge wclk) begin
    if (wr_reset) begin
      overflow <= 1'b0;
    end else if (w_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_pointer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_pointer_ctrl
// Purpose  : Directed and randomised self-checking bench for
//            write_pointer_ctrl with PTRWIDTH=3 (depth 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_write_pointer_ctrl;

  logic       wclk = 1'b0;
  logic       wr_reset;
  logic       w_en;
  logic [3:0] g_rdptr_sync;
  logic [3:0] af_thresh;
  logic       ovf_clr;
  logic [3:0] b_wrptr;
  logic [3:0] g_wrptr;
  logic [2:0] wr_addr;
  logic       wr_accept;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Hand-written Gray sequence for binary 0..8.
  logic [3:0] gray_tbl [0:8];

  write_pointer_ctrl #(.PTRWIDTH(3)) dut (
    .wclk         (wclk),
    .wr_reset     (wr_reset),
    .w_en         (w_en),
    .g_rdptr_sync (g_rdptr_sync),
    .af_thresh    (af_thresh),
    .ovf_clr      (ovf_clr),
    .b_wrptr      (b_wrptr),
    .g_wrptr      (g_wrptr),
    .wr_addr      (wr_addr),
    .wr_accept    (wr_accept),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow     (overflow)
  );

  // Free-running write clock.
  always #5 wclk = ~wclk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wr_reset = 1'b1; w_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({b_wrptr, g_wrptr, full, almost_full, wr_level, overflow} !== 16'h0) begin
        miscompares++;
        $display("FAIL reset: b=%0h g=%0h full=%0b af=%0b lvl=%0d ovf=%0b, want all 0",
                 b_wrptr, g_wrptr, full, almost_full, wr_level, overflow);
      end
    end
    wr_reset = 1'b0; w_en = 1'b0;
  endtask

  task automatic test_fill();
    g_rdptr_sync = 4'b0000; af_thresh = 4'd6; w_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      vectors++;
      if (wr_accept !== 1'b1) begin
        miscompares++;
        $display("FAIL fill accept %0d: got %0b want 1", i, wr_accept);
      end
      tick();
      vectors++;
      if (b_wrptr !== 4'(i) || g_wrptr !== gray_tbl[i] || wr_level !== 4'(i) ||
          wr_addr !== 3'(i) || almost_full !== (i >= 6) || full !== (i == 8)) begin
        miscompares++;
        $display("FAIL fill step %0d: b=%0h g=%0h addr=%0d lvl=%0d af=%0b full=%0b, want b=%0h g=%0h lvl=%0d af=%0b full=%0b",
                 i, b_wrptr, g_wrptr, wr_addr, wr_level, almost_full, full,
                 i, gray_tbl[i], i, (i >= 6), (i == 8));
      end
    end
    vectors++;
    if (b_wrptr !== 4'b1000 || g_wrptr !== 4'b1100 || wr_level !== 4'd8) begin
      miscompares++;
      $display("FAIL fill final: b=%b g=%b lvl=%0d want 1000 1100 8", b_wrptr, g_wrptr, wr_level);
    end
  endtask

  task automatic test_overflow();
    w_en = 1'b1; ovf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (wr_accept !== 1'b0) begin
        miscompares++;
        $display("FAIL ovf accept: got %0b want 0", wr_accept);
      end
      tick();
      vectors++;
      if (b_wrptr !== 4'd8 || overflow !== 1'b1 || full !== 1'b1 || wr_level !== 4'd8) begin
        miscompares++;
        $display("FAIL ovf hold: b=%0d ovf=%0b full=%0b lvl=%0d want 8 1 1 8",
                 b_wrptr, overflow, full, wr_level);
      end
    end
    ovf_clr = 1'b1;
    tick();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf set-beats-clear: got %0b want 1", overflow);
    end
    w_en = 1'b0;
    tick();
    vectors++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf clear: ovf=%0b full=%0b want 0 1", overflow, full);
    end
    ovf_clr = 1'b0;
  endtask

  task automatic test_drain_wrap();
    w_en = 1'b0; g_rdptr_sync = 4'b0110;
    tick();
    vectors++;
    if (full !== 1'b0 || wr_level !== 4'd4 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: full=%0b lvl=%0d af=%0b want 0 4 0", full, wr_level, almost_full);
    end
    w_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (wr_level !== 4'(4 + i) || full !== (i == 4) || b_wrptr !== 4'(8 + i)) begin
        miscompares++;
        $display("FAIL refill %0d: b=%0d lvl=%0d full=%0b want b=%0d lvl=%0d full=%0b",
                 i, b_wrptr, wr_level, full, 8 + i, 4 + i, (i == 4));
      end
    end
    vectors++;
    if (b_wrptr !== 4'b1100 || g_wrptr !== 4'b1010) begin
      miscompares++;
      $display("FAIL refill final: b=%b g=%b want 1100 1010", b_wrptr, g_wrptr);
    end
    // Read side catches up to binary 12.
    w_en = 1'b0; g_rdptr_sync = 4'b1010;
    tick();
    vectors++;
    if (full !== 1'b0 || wr_level !== 4'd0) begin
      miscompares++;
      $display("FAIL catchup: full=%0b lvl=%0d want 0 0", full, wr_level);
    end
    w_en = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    w_en = 1'b0;
    vectors++;
    if (b_wrptr !== 4'd0 || g_wrptr !== 4'd0 || wr_level !== 4'd4 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: b=%0d g=%0d lvl=%0d full=%0b want 0 0 4 0",
               b_wrptr, g_wrptr, wr_level, full);
    end
  endtask

  task automatic test_midop_reset();
    wr_reset = 1'b1; w_en = 1'b0;
    tick();
    wr_reset = 1'b0; g_rdptr_sync = 4'b0000; w_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (b_wrptr !== 4'd5 || wr_level !== 4'd5) begin
      miscompares++;
      $display("FAIL midop pre: b=%0d lvl=%0d want 5 5", b_wrptr, wr_level);
    end
    wr_reset = 1'b1;
    tick();
    vectors++;
    if (b_wrptr !== 4'd0 || g_wrptr !== 4'd0 || full !== 1'b0 || wr_level !== 4'd0 ||
        overflow !== 1'b0 || almost_full !== 1'b0) begin
      miscompares++;
      $display("FAIL midop reset: b=%0d g=%0d full=%0b lvl=%0d ovf=%0b af=%0b want all 0",
               b_wrptr, g_wrptr, full, wr_level, overflow, almost_full);
    end
    wr_reset = 1'b0; w_en = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] m_b, m_lvl, rb, rb_d1, rb_d2, nb, nlvl, rb_n;
    logic       m_full, m_af, m_ovf, acc, nfull, naf, novf;
    wr_reset = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; af_thresh = 4'd5;
    g_rdptr_sync = 4'b0000;
    tick();
    wr_reset = 1'b0;
    m_b = '0; m_lvl = '0; rb = '0; rb_d1 = '0; rb_d2 = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      w_en    = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      g_rdptr_sync = to_gray(rb_d2);
      #1;
      acc  = w_en & ~m_full;
      nb   = m_b + {3'b000, acc};
      nlvl = nb - rb_d2;
      nfull = (nlvl == 4'd8);
      naf   = (nlvl >= af_thresh);
      novf  = (w_en & m_full) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      rb_n  = (rb != m_b && $urandom_range(0, 2) != 0) ? rb + 4'd1 : rb;
      vectors++;
      if (wr_accept !== acc) begin
        miscompares++;
        $display("FAIL rand accept cyc %0d: got %0b want %0b", c, wr_accept, acc);
      end
      tick();
      m_b = nb; m_lvl = nlvl; m_full = nfull; m_af = naf; m_ovf = novf;
      rb_d2 = rb_d1; rb_d1 = rb; rb = rb_n;
      vectors++;
      if (wr_level !== m_lvl || full !== m_full || almost_full !== m_af ||
          overflow !== m_ovf || b_wrptr !== m_b) begin
        miscompares++;
        $display("FAIL rand cyc %0d: lvl=%0d full=%0b af=%0b ovf=%0b b=%0d want %0d %0b %0b %0b %0d",
                 c, wr_level, full, almost_full, overflow, b_wrptr,
                 m_lvl, m_full, m_af, m_ovf, m_b);
      end
    end
    w_en = 1'b0; ovf_clr = 1'b0;
  endtask

  // Test sequence.
  initial begin
    gray_tbl[0] = 4'b0000; gray_tbl[1] = 4'b0001; gray_tbl[2] = 4'b0011;
    gray_tbl[3] = 4'b0010; gray_tbl[4] = 4'b0110; gray_tbl[5] = 4'b0111;
    gray_tbl[6] = 4'b0101; gray_tbl[7] = 4'b0100; gray_tbl[8] = 4'b1100;
    wr_reset = 1'b1; w_en = 1'b0; g_rdptr_sync = 4'b0000;
    af_thresh = 4'd6; ovf_clr = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_wrap();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
